shift_pattern_ctrl: RTL and testbench
=====================================

// Module: shift_pattern_ctrl
// PURPOSE
//  Parametrised pattern controller for a daisy chain of N_CHIPS 74hc595 registers.
//  Sits in front of the serial shifter and drives its o_data/o_enable handshake.
//  Adds four pattern modes, a runtime interval, a run/stop control and host-loaded data.
//  Also supports one-shot host frames and a frame counter.
// PARAMETERS
//  N_CHIPS  2   number of chained 74hc595; data width W = 8*N_CHIPS
//  TIMER_W  25  width of interval counter and i_interval
// PORTS
//  i_clk        in   1        system clock, all logic on rising edge
//  i_rst_n      in   1        asynchronous, active-low reset
//  i_run        in   1        1 = free-running frames, 0 = stop after current frame
//  i_mode       in   2        0 toggle, 1 rotate-left, 2 up-counter, 3 host data
//  i_interval   in   TIMER_W  clock cycles between frames; 0 treated as 1
//  i_host_data  in   W        host pattern
//  i_host_load  in   1        one-cycle strobe, latches i_host_data
//  i_ready      in   1        shifter idle/ready
//  o_data       out  W        pattern presented to shifter
//  o_enable     out  1        one-cycle start-shift pulse
//  o_busy       out  1        high in every state except IDLE
//  o_frame_cnt  out  8        frames started, wraps 255->0
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - o_data={N_CHIPS{8'h55}}, shadow=same, o_enable=0, o_busy=0, o_frame_cnt=0
//   - timer=0, state=IDLE; applies immediately, mid-operation included
//  FSM: IDLE -> START -> SETTLE -> WAIT_RDY -> INTERVAL -> UPDATE -> START ...
//   IDLE: stays while i_run=0 and no one-shot request
//     - i_run=1 -> START
//     - i_host_load=1 and i_mode=3 -> START (one-shot)
//   START: o_enable=1 for exactly this cycle; o_frame_cnt+1; -> SETTLE
//   SETTLE: o_enable=0; one cycle so the shifter can drop i_ready; -> WAIT_RDY
//   WAIT_RDY: hold until i_ready=1
//     - then i_run=1 -> INTERVAL (timer cleared)
//     - then i_run=0 -> IDLE (covers one-shot and stop)
//   INTERVAL: timer+1 each cycle
//     - i_run=0 -> IDLE immediately
//     - timer reaches max(i_interval,1)-1 -> UPDATE
//   UPDATE: compute next o_data from i_mode sampled this cycle; -> START
//     - mode 0: ~o_data
//     - mode 1: {o_data[W-2:0], o_data[W-1]}
//     - mode 2: o_data+1, mod 2^W (all-ones -> 0)
//     - mode 3: o_data <= shadow
//  o_data changes only in UPDATE or IDLE; never while a shift is in progress.
//  Host data:
//   - i_host_load writes shadow in any state
//   - in IDLE it also writes o_data the same edge
//   - load coinciding with UPDATE in mode 3: UPDATE uses the new i_host_data
//  First frame after IDLE sends the current o_data, with no UPDATE.
//  i_run is sampled only in IDLE, WAIT_RDY (on exit) and INTERVAL.
//   - deasserting i_run mid-shift always completes the frame
//  Frame period with i_ready immediate: 3 + max(i_interval,1) + 1 cycles.
//  i_interval and i_mode may change at any time; taken at next compare/UPDATE.
// TESTING
//  1 N_CHIPS=2, mode0, i_interval=4, run=1, model ready 3 cyc after enable:
//    - o_data 5555, AAAA, 5555
//    - single-cycle enables, period 3+3+4+1 = 11
//  2 idle load 0001, mode1, run=1:
//    - 0001, 0002, ..., 8000, then 0001 (wrap)
//  3 idle load FFFE, mode2:
//    - FFFE, FFFF, 0000
//    - 260 frames -> o_frame_cnt=4 (wrap)
//  4 mode3, run=0, pulse load 1234:
//    - one enable with o_data=1234, frame_cnt+1
//    - busy falls after ready; no further enables
//  5 run falls during WAIT_RDY:
//    - frame completes, IDLE, o_busy=0, no later enable
//    - o_data unchanged
//  6 i_rst_n low mid-INTERVAL (async, between edges):
//    - outputs at reset values before next edge
//    - restart sends 5555 first

Source files
------------

// File: rtl/shift_pattern_ctrl.sv
// Pattern controller for a daisy chain of 74hc595 shift registers.
// Produces the frame pattern and a one-cycle start pulse for the serial shifter,
// paces frames with a runtime interval and counts the frames it starts.
module shift_pattern_ctrl #(
    parameter int N_CHIPS = 2,
    parameter int TIMER_W = 25
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_run,
    input  logic [1:0]             i_mode,
    input  logic [TIMER_W-1:0]     i_interval,
    input  logic [8*N_CHIPS-1:0]   i_host_data,
    input  logic                   i_host_load,
    input  logic                   i_ready,
    output logic [8*N_CHIPS-1:0]   o_data,
    output logic                   o_enable,
    output logic                   o_busy,
    output logic [7:0]             o_frame_cnt
);

    localparam int W = 8 * N_CHIPS;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] SETTLE   = 3'd2;
    localparam logic [2:0] WAIT_RDY = 3'd3;
    localparam logic [2:0] INTERVAL = 3'd4;
    localparam logic [2:0] UPDATE   = 3'd5;

    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [W-1:0]       DATA_ONE  = W'(1);
    localparam logic [W-1:0]       DATA_RST  = {N_CHIPS{8'h55}};

    logic [2:0]         state_q, state_d;
    logic [W-1:0]       data_q, data_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [TIMER_W-1:0] timer_last;
    logic               timer_done;

    // An interval of zero behaves like one: the last timer value is then also zero.
    assign timer_last = (i_interval == '0) ? '0 : (i_interval - TIMER_ONE);
    assign timer_done = (timer_q == timer_last);

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_run || (i_host_load && (i_mode == 2'd3))) begin
                    state_d = START;
                end
            end
            START:    state_d = SETTLE;
            SETTLE:   state_d = WAIT_RDY;
            WAIT_RDY: begin
                if (i_ready) begin
                    state_d = i_run ? INTERVAL : IDLE;
                end
            end
            INTERVAL: begin
                if (!i_run) begin
                    state_d = IDLE;
                end else if (timer_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE:   state_d = START;
            default:  state_d = IDLE;
        endcase
    end

    // Pattern, shadow, timer and frame counter next values.
    always_comb begin
        data_d      = data_q;
        shadow_d    = i_host_load ? i_host_data : shadow_q;
        // Timer only runs in INTERVAL, so it is already clear on WAIT_RDY exit.
        timer_d     = (state_q == INTERVAL) ? (timer_q + TIMER_ONE) : '0;
        frame_cnt_d = (state_q == START) ? (frame_cnt_q + 8'd1) : frame_cnt_q;
        if ((state_q == IDLE) && i_host_load) begin
            data_d = i_host_data;
        end else if (state_q == UPDATE) begin
            case (i_mode)
                2'd0:    data_d = ~data_q;
                2'd1:    data_d = {data_q[W-2:0], data_q[W-1]};
                2'd2:    data_d = data_q + DATA_ONE;
                default: data_d = i_host_load ? i_host_data : shadow_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            data_q      <= DATA_RST;
            shadow_q    <= DATA_RST;
            timer_q     <= '0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shadow_q    <= shadow_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_enable    = (state_q == START);
    assign o_busy      = (state_q != IDLE);
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_shift_pattern_ctrl.sv
// Directed self-checking bench for shift_pattern_ctrl (N_CHIPS=2).
module tb_shift_pattern_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_run;
    logic [1:0]  i_mode;
    logic [24:0] i_interval;
    logic [15:0] i_host_data;
    logic        i_host_load;
    logic        i_ready;
    logic [15:0] o_data;
    logic        o_enable;
    logic        o_busy;
    logic [7:0]  o_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_lat  = 4;
    int rdy_cnt  = 0;

    shift_pattern_ctrl #(
        .N_CHIPS(2),
        .TIMER_W(25)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (i_run),
        .i_mode      (i_mode),
        .i_interval  (i_interval),
        .i_host_data (i_host_data),
        .i_host_load (i_host_load),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_enable    (o_enable),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Shifter model: ready drops on the edge that samples enable and returns
    // rdy_lat edges later.
    always @(posedge i_clk) begin
        if (o_enable) begin
            i_ready <= 1'b0;
            rdy_cnt <= rdy_lat;
        end else if (rdy_cnt > 1) begin
            rdy_cnt <= rdy_cnt - 1;
        end else if (rdy_cnt == 1) begin
            rdy_cnt <= 0;
            i_ready <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_enable(input int budget, input string tag, output int t);
        logic seen;
        seen = 1'b0;
        t = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge i_clk);
            if (o_enable) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check_eq({tag, " enable seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge i_clk);
            if (!o_busy) idle = 1'b1;
        end
        check_eq({tag, " idle reached"}, 32'(idle), 32'd1);
    endtask

    task automatic no_enable(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (o_enable) cnt++;
        end
        check_eq({tag, " no enables"}, 32'(cnt), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic idle_load(input logic [15:0] d);
        @(negedge i_clk);
        i_host_data = d;
        i_host_load = 1'b1;
        @(negedge i_clk);
        i_host_load = 1'b0;
    endtask

    initial begin
        int t0, t1;
        logic [15:0] exp;
        i_rst_n     = 1'b0;
        i_run       = 1'b0;
        i_mode      = 2'd0;
        i_interval  = 25'd4;
        i_host_data = 16'h0;
        i_host_load = 1'b0;
        i_ready     = 1'b1;
        #12;
        check_eq("rst data", 32'(o_data), 32'h5555);
        check_eq("rst enable", 32'(o_enable), 32'd0);
        check_eq("rst busy", 32'(o_busy), 32'd0);
        check_eq("rst frame_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1: toggle mode, interval 4, ready returns 4 edges after enable.
        rdy_lat = 4;
        @(negedge i_clk);
        i_run = 1'b1;
        wait_enable(20, "t1 f0", t0);
        check_eq("t1 f0 data", 32'(o_data), 32'h5555);
        @(negedge i_clk);
        check_eq("t1 enable width", 32'(o_enable), 32'd0);
        wait_enable(30, "t1 f1", t1);
        check_eq("t1 f1 data", 32'(o_data), 32'hAAAA);
        check_eq("t1 period a", 32'(t1 - t0), 32'd11);
        t0 = t1;
        wait_enable(30, "t1 f2", t1);
        check_eq("t1 f2 data", 32'(o_data), 32'h5555);
        check_eq("t1 period b", 32'(t1 - t0), 32'd11);
        i_run = 1'b0;
        wait_idle(30, "t1");
        check_eq("t1 frame_cnt", 32'(o_frame_cnt), 32'd3);

        // 2: rotate-left from 0001, interval 0 treated as 1.
        i_mode = 2'd1;
        idle_load(16'h0001);
        check_eq("t2 idle load", 32'(o_data), 32'h0001);
        check_eq("t2 load no start", 32'(o_busy), 32'd0);
        i_interval = 25'd0;
        rdy_lat = 1;
        i_run = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wait_enable(20, "t2", t1);
            exp = (k < 16) ? (16'h0001 << k) : 16'h0001;
            check_eq("t2 rotate data", 32'(o_data), 32'(exp));
            if (k == 1) check_eq("t2 period", 32'(t1 - t0), 32'd5);
            t0 = t1;
            if (k == 16) i_run = 1'b0;
        end
        wait_idle(30, "t2");

        // 3: up-counter from FFFE through the wrap, 260 frames.
        pulse_reset();
        i_mode = 2'd2;
        idle_load(16'hFFFE);
        i_interval = 25'd1;
        i_run = 1'b1;
        for (int k = 0; k < 260; k++) begin
            wait_enable(20, "t3", t1);
            exp = 16'hFFFE + 16'(k);
            check_eq("t3 count data", 32'(o_data), 32'(exp));
            if (k == 259) i_run = 1'b0;
        end
        wait_idle(30, "t3");
        check_eq("t3 frame_cnt wrap", 32'(o_frame_cnt), 32'd4);

        // 4: one-shot host frame with run low.
        i_mode = 2'd3;
        rdy_lat = 4;
        idle_load(16'h1234);
        check_eq("t4 oneshot enable", 32'(o_enable), 32'd1);
        check_eq("t4 oneshot data", 32'(o_data), 32'h1234);
        wait_idle(30, "t4");
        check_eq("t4 frame_cnt", 32'(o_frame_cnt), 32'd5);
        no_enable(30, "t4");

        // 5: run falls while waiting for ready.
        i_mode = 2'd0;
        i_interval = 25'd2;
        i_run = 1'b1;
        wait_enable(20, "t5", t1);
        check_eq("t5 first data", 32'(o_data), 32'h1234);
        @(negedge i_clk);
        @(negedge i_clk);
        check_eq("t5 busy in wait", 32'(o_busy), 32'd1);
        i_run = 1'b0;
        wait_idle(30, "t5");
        check_eq("t5 data held", 32'(o_data), 32'h1234);
        check_eq("t5 frame_cnt", 32'(o_frame_cnt), 32'd6);
        no_enable(30, "t5");

        // 6: asynchronous reset in the middle of INTERVAL.
        i_interval = 25'd10;
        rdy_lat = 1;
        i_run = 1'b1;
        wait_enable(20, "t6", t1);
        for (int i = 0; i < 4; i++) @(negedge i_clk);
        check_eq("t6 busy pre-reset", 32'(o_busy), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("t6 async data", 32'(o_data), 32'h5555);
        check_eq("t6 async enable", 32'(o_enable), 32'd0);
        check_eq("t6 async busy", 32'(o_busy), 32'd0);
        check_eq("t6 async frame_cnt", 32'(o_frame_cnt), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_enable(20, "t6 restart", t1);
        check_eq("t6 restart data", 32'(o_data), 32'h5555);
        @(negedge i_clk);
        check_eq("t6 restart frame_cnt", 32'(o_frame_cnt), 32'd1);
        i_run = 1'b0;
        wait_idle(30, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
